// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - stage index defaults and control-mode encoding for pipeline_ctrl
package pipeline_ctrl_pkg;

    localparam int STG_DEC = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_DSTALL,
        MODE_FLUSH,
        MODE_HAZARD,
        MODE_IWAIT,
        MODE_ADV
    } ctrl_mode_t;

    // Modes that inject an empty slot into the pipe without killing anything.
    function automatic logic mode_is_bubble(input ctrl_mode_t m);
        return (m == MODE_HAZARD) || (m == MODE_IWAIT);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - datapath <-> pipeline controller handshake bundle
interface pipeline_ctrl_if #(
    parameter int NUM_STAGES = 5
) ();

    logic                  inst_resp;
    logic                  data_read;
    logic                  data_write;
    logic                  data_resp;
    logic                  hazard_stall;
    logic                  flush;
    logic [NUM_STAGES-1:0] load;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  pc_load;
    logic                  flush_taken;

    modport master (
        output inst_resp,
        output data_read,
        output data_write,
        output data_resp,
        output hazard_stall,
        output flush,
        input  load,
        input  stage_valid,
        input  pc_load,
        input  flush_taken
    );

    modport slave (
        input  inst_resp,
        input  data_read,
        input  data_write,
        input  data_resp,
        input  hazard_stall,
        input  flush,
        output load,
        output stage_valid,
        output pc_load,
        output flush_taken
    );

endinterface

// File: rtl/pipeline_perf_counters.sv
// rtl/pipeline_perf_counters.sv - saturating stall/bubble/flush event counters
module pipeline_perf_counters
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  ctrl_mode_t       mode,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_evt;
    logic bubble_evt;
    logic flush_evt;

    assign stall_evt  = (mode == MODE_DSTALL);
    assign bubble_evt = mode_is_bubble(mode);
    assign flush_evt  = (mode == MODE_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall_evt && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble_evt && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/bubble controller for the in-order pipeline
// Optional event counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = STG_WB + 1,
    parameter int HZ_STAGE    = STG_DEC,
    parameter int FLUSH_STAGE = STG_EX,
    parameter int MEM_STAGE   = STG_MEM,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    generate
        if (!((NUM_STAGES >= 3) && (HZ_STAGE >= 0) && (HZ_STAGE < FLUSH_STAGE) &&
              (FLUSH_STAGE < MEM_STAGE) && (MEM_STAGE < NUM_STAGES) && (CNT_W >= 1))) begin : g_bad_params
            $error("pipeline_ctrl: illegal stage/counter parameters");
        end
    endgenerate

    ctrl_mode_t            mode;
    logic                  dmem_stall;
    logic                  imem_wait;
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] valid_next;
    logic [NUM_STAGES-1:0] load_c;
    logic                  pc_load_c;
    logic                  flush_taken_c;

    assign dmem_stall = (bus.data_read | bus.data_write) & ~bus.data_resp;
    assign imem_wait  = ~bus.inst_resp;

    // Fixed-priority decode; a data_resp cycle falls through as if no request existed.
    always_comb begin
        mode = MODE_ADV;
        if (rst) begin
            mode = MODE_RESET;
        end else if (dmem_stall) begin
            mode = MODE_DSTALL;
        end else if (bus.flush) begin
            mode = MODE_FLUSH;
        end else if (bus.hazard_stall) begin
            mode = MODE_HAZARD;
        end else if (imem_wait) begin
            mode = MODE_IWAIT;
        end
    end

    always_comb begin
        load_c        = '0;
        pc_load_c     = 1'b0;
        flush_taken_c = 1'b0;
        valid_next    = valid_q;
        case (mode)
            MODE_RESET: begin
                valid_next = '0;
            end
            MODE_DSTALL: begin
                valid_next = valid_q;
            end
            MODE_FLUSH: begin
                load_c        = '1;
                pc_load_c     = 1'b1;
                flush_taken_c = 1'b1;
                valid_next[0] = 1'b0;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    valid_next[k] = (k <= FLUSH_STAGE) ? 1'b0 : valid_q[k-1];
                end
            end
            MODE_HAZARD: begin
                // Stages up to HZ_STAGE hold; a bubble enters just behind them.
                for (int k = 0; k < NUM_STAGES; k++) begin
                    load_c[k] = (k > HZ_STAGE);
                end
                for (int k = 1; k < NUM_STAGES; k++) begin
                    if (k == HZ_STAGE + 1) begin
                        valid_next[k] = 1'b0;
                    end else if (k > HZ_STAGE + 1) begin
                        valid_next[k] = valid_q[k-1];
                    end
                end
            end
            MODE_IWAIT: begin
                load_c     = '1;
                valid_next = {valid_q[NUM_STAGES-2:0], 1'b0};
            end
            MODE_ADV: begin
                load_c     = '1;
                pc_load_c  = 1'b1;
                valid_next = {valid_q[NUM_STAGES-2:0], 1'b1};
            end
            default: begin
                valid_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_next;
        end
    end

    assign bus.load        = load_c;
    assign bus.stage_valid = valid_q;
    assign bus.pc_load     = pc_load_c;
    assign bus.flush_taken = flush_taken_c;

`ifdef PIPELINE_CTRL_PERF_EN
    pipeline_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - instruction-tracking model plus directed vectors for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int NS = 5;
    localparam int HZ = 0;
    localparam int FS = 1;
    localparam int MS = 3;
    localparam int CW = 16;

    logic clk;
    logic rst;
    logic chk_en;
    int   checks;
    int   failures;

    pipeline_ctrl_if #(.NUM_STAGES(NS)) bus ();

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipeline_ctrl #(
        .NUM_STAGES  (NS),
        .HZ_STAGE    (HZ),
        .FLUSH_STAGE (FS),
        .MEM_STAGE   (MS),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stage holds an instruction id (0 = empty); fetches hand out rising ids.
    int             id_q [NS];
    int             id_n [NS];
    int             next_id;
    int             last_retired;
    logic           m_dst;
    logic [NS-1:0]  e_load;
    logic [NS-1:0]  e_valid;
    logic           e_pc;
    logic           e_ft;
    logic           shifts;

    initial begin
        for (int k = 0; k < NS; k++) id_q[k] = 0;
        next_id      = 1;
        last_retired = 0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            m_dst  = (bus.data_read | bus.data_write) & ~bus.data_resp;
            e_load = '0;
            e_pc   = 1'b0;
            e_ft   = 1'b0;
            shifts = 1'b0;
            for (int k = 0; k < NS; k++) e_valid[k] = (id_q[k] != 0);
            for (int k = 0; k < NS; k++) id_n[k] = id_q[k];

            if (rst) begin
                for (int k = 0; k < NS; k++) id_n[k] = 0;
            end else if (m_dst) begin
                e_load = '0;
            end else if (bus.flush) begin
                e_load = '1; e_pc = 1'b1; e_ft = 1'b1; shifts = 1'b1;
                for (int k = NS - 1; k >= 1; k--) id_n[k] = id_q[k-1];
                for (int k = 0; k <= FS; k++) id_n[k] = 0;
            end else if (bus.hazard_stall) begin
                for (int k = HZ + 1; k < NS; k++) e_load[k] = 1'b1;
                shifts = 1'b1;
                for (int k = NS - 1; k > HZ + 1; k--) id_n[k] = id_q[k-1];
                id_n[HZ+1] = 0;
            end else begin
                e_load = '1; e_pc = bus.inst_resp; shifts = 1'b1;
                for (int k = NS - 1; k >= 1; k--) id_n[k] = id_q[k-1];
                id_n[0] = bus.inst_resp ? next_id : 0;
                if (bus.inst_resp) next_id++;
            end

            check("load", bus.load, e_load);
            check("pc_load", bus.pc_load, e_pc);
            check("flush_taken", bus.flush_taken, e_ft);
            check("stage_valid", bus.stage_valid, e_valid);
            if (shifts && id_q[NS-1] != 0) begin
                check("retire_order", (id_q[NS-1] > last_retired), 1);
                last_retired = id_q[NS-1];
            end
            for (int k = 0; k < NS; k++) id_q[k] = id_n[k];
        end
    end

    task automatic cyc(input logic r, input logic ir, input logic dr, input logic dw,
                       input logic drs, input logic hz, input logic fl);
        @(posedge clk);
        #1;
        rst              = r;
        bus.inst_resp    = ir;
        bus.data_read    = dr;
        bus.data_write   = dw;
        bus.data_resp    = drs;
        bus.hazard_stall = hz;
        bus.flush        = fl;
        @(negedge clk);
    endtask

    task automatic refill();
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        check("refill_valid", bus.stage_valid, 5'b11111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CW-1:0] bub_base;
`endif

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus.inst_resp = 1'b0; bus.data_read = 1'b0; bus.data_write = 1'b0;
        bus.data_resp = 1'b0; bus.hazard_stall = 1'b0; bus.flush = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        cyc(1, 1, 0, 0, 0, 0, 0);
        check("rst_load", bus.load, 5'b00000);
        check("rst_pc_load", bus.pc_load, 0);
        check("rst_valid", bus.stage_valid, 5'b00000);

        for (int i = 1; i <= 6; i++) begin
            logic [NS-1:0] ev;
            ev = NS'((1 << (i - 1)) - 1);
            cyc(0, 1, 0, 0, 0, 0, 0);
            check("fill_valid", bus.stage_valid, ev);
            check("fill_pc_load", bus.pc_load, 1);
        end

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            check("dstall_load", bus.load, 5'b00000);
            check("dstall_pc_load", bus.pc_load, 0);
            check("dstall_valid", bus.stage_valid, 5'b11111);
        end
        cyc(0, 1, 1, 0, 1, 0, 0);
        check("dresp_load", bus.load, 5'b11111);
        check("dresp_pc_load", bus.pc_load, 1);

        cyc(0, 1, 0, 0, 0, 1, 0);
        check("hazard_load", bus.load, 5'b11110);
        check("hazard_pc_load", bus.pc_load, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("hazard_bubble", bus.stage_valid, 5'b11101);
        refill();

        cyc(0, 1, 0, 0, 0, 1, 1);
        check("flushhz_taken", bus.flush_taken, 1);
        check("flushhz_pc_load", bus.pc_load, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("flush_valid", bus.stage_valid, 5'b11100);
        refill();

        cyc(0, 1, 1, 0, 0, 0, 1);
        check("flush_in_dstall_0", bus.flush_taken, 0);
        cyc(0, 1, 1, 0, 0, 1, 1);
        check("flush_in_dstall_1", bus.flush_taken, 0);
        cyc(0, 1, 1, 0, 1, 0, 1);
        check("flush_at_dresp", bus.flush_taken, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("flush_once", bus.flush_taken, 0);
        refill();

        cyc(0, 1, 0, 1, 0, 0, 0);
        check("dwrite_stall", bus.load, 5'b00000);
        cyc(0, 1, 0, 1, 1, 0, 0);
        check("dwrite_resp", bus.load, 5'b11111);
        cyc(0, 1, 1, 0, 0, 0, 0);
        check("back2back_stall", bus.load, 5'b00000);
        cyc(0, 1, 1, 0, 1, 0, 0);
        refill();

        cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef PIPELINE_CTRL_PERF_EN
        bub_base = bubble_cnt;
`endif
        check("iwait_load", bus.load, 5'b11111);
        check("iwait_pc_load", bus.pc_load, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("iwait_valid_1", bus.stage_valid, 5'b11110);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("iwait_valid_2", bus.stage_valid, 5'b11100);
`ifdef PIPELINE_CTRL_PERF_EN
        check("bubble_cnt", 32'(bubble_cnt - bub_base), 2);
`endif
        refill();

        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        check("hazard_held_valid", bus.stage_valid, 5'b11101);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("hazard_two_bubbles", bus.stage_valid, 5'b11001);

        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 1);
        check("midstall_rst_load", bus.load, 5'b00000);
        check("midstall_rst_ft", bus.flush_taken, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("post_rst_valid", bus.stage_valid, 5'b00000);
        check("post_rst_pc_load", bus.pc_load, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("post_rst_first", bus.stage_valid, 5'b00001);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
